alu_serial_ctrl: RTL and testbench
==================================

# alu_serial_ctrl

Bit-serial sequencer that drives one external 1-bit ALU slice to execute a full WIDTH-bit operation, LSB first, one bit per clock. It accepts an operation and two operands over a valid/ready handshake. It generates the slice's invert, carry-in, less and operation controls and feeds the operands bit by bit. It also registers the carry chain and assembles the result, flags and a done handshake. It is the low-area alternative to the ripple-carry datapath of the 24-bit CPU and sits between the decode stage and a single slice instance.

## Interface
- WIDTH, 24, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- start_valid  in  1  request valid
- start_ready  out  1  high only in IDLE
- func  in  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 XOR, 6 NOR, 7 illegal
- op_a, op_b  in  WIDTH  operands, sampled on start handshake
- slice_a, slice_b  out  1  current operand bits
- slice_ainvert, slice_binvert  out  1  invert controls
- slice_cin  out  1  carry into current bit
- slice_less  out  1  LESS input to slice
- slice_op  out  3  slice operation: 0 AND, 1 OR, 2 ADD, 3 LESS, 4 XOR
- slice_cout, slice_result  in  1  slice outputs, same cycle
- done_valid  out  1  result valid
- done_ready  in  1  consumer accepts result
- result  out  WIDTH  assembled result
- zero, carry, overflow, err  out  1  flags, valid with done_valid

## Operation
- States: IDLE, RUN, FIX, DONE.
- **IDLE**
  - start_valid & start_ready latches func, op_a and op_b into shift registers and clears bit index, result and flags.
  - func 7 goes to DONE with result 0 and err=1. All other funcs go to RUN.
- **RUN** (bit index i = 0..WIDTH-1)
  - slice_a and slice_b carry op_a[i] and op_b[i].
  - Controls per func:
    - AND: op 0
    - OR: op 1
    - ADD: op 2, ainv=0, binv=0
    - SUB: op 2, binv=1
    - SLT: op 2, binv=1
    - XOR: op 4
    - NOR: op 0, ainv=1, binv=1
  - slice_cin: 1 at i=0 for SUB/SLT, 0 at i=0 otherwise; for i>0 it is the registered slice_cout of bit i-1.
  - result[i] takes slice_result at each edge.
  - At i=WIDTH-1:
    - carry takes slice_cout.
    - overflow = slice_cin ^ slice_cout, for ADD/SUB/SLT only; 0 for all other funcs.
    - set = slice_result ^ overflow.
    - SLT goes to FIX; all other funcs go to DONE.
- **FIX** (SLT only, one cycle)
  - Drives slice_op=3 and slice_less=set.
  - result becomes {WIDTH-1 zeros, slice_result}, then DONE.
- **DONE**
  - done_valid=1. result and flags are held stable.
  - zero = (result==0).
  - done_valid & done_ready goes to IDLE.
- slice_less=0 outside FIX. All slice_* outputs are 0 in IDLE and DONE.

## Timing
- Reset (asynchronous): state IDLE, start_ready=1, done_valid=0, result=0, all flags 0, all slice_* outputs 0.
- Latency from the start handshake edge to done_valid high:
  - WIDTH cycles for ops 0–3, 5, 6.
  - WIDTH+1 cycles for SLT.
  - 1 cycle for func 7.
- No back-to-back accept: start_ready rises in the cycle after the done handshake.
- Backpressure: done_valid stays high indefinitely while done_ready=0, with no output change.
- start_valid is ignored outside IDLE.
- Operands and func changing after acceptance have no effect.
- Reset asserted mid-RUN or mid-FIX aborts immediately. The partial result is discarded and not reported.
- Carry register is cleared on every accept, so no carry leaks between operations.

## Structure
- Package alu_serial_pkg holds:
  - the func enum (3 bits)
  - the slice op constants (3 bits)
  - the state enum
  - WIDTH default 24
- One sub-module, operand_shreg: a WIDTH-bit load/shift-right register with parallel load and serial LSB output, used twice (A and B).
- Control decode is a combinational function of func and state. The slice itself is instantiated outside this block.

## Test plan
- ADD 0x7FFFFF + 0x000001 -> result 0x800000, overflow=1, carry=0, zero=0; done_valid exactly 24 cycles after accept.
- SUB 0x000005 - 0x000005 -> result 0x000000, zero=1, carry=1, overflow=0.
- SLT 0xFFFFFF vs 0x000001 -> result 0x000001 after 25 cycles. Reversed operands -> result 0x000000.
- NOR 0,0 -> 0xFFFFFF; XOR 0xA5A5A5 ^ 0x0F0F0F -> 0xAAAAAA. Hold done_ready=0 for 10 cycles: outputs are stable and start_ready=0 throughout.
- func 7 -> done_valid 1 cycle after accept with err=1 and result 0.
- rst_n low at bit 12 of an ADD -> all outputs 0 immediately. A fresh ADD 3+4 then gives 7 with no stale carry.

Source files
------------

// File: rtl/alu_serial_ctrl_pkg.sv
// Shared types, constants and control decode for the bit-serial ALU sequencer.
package alu_serial_pkg;

    localparam int unsigned DEF_WIDTH = 24;

    typedef enum logic [2:0] {
        FN_AND = 3'd0,
        FN_OR  = 3'd1,
        FN_ADD = 3'd2,
        FN_SUB = 3'd3,
        FN_SLT = 3'd4,
        FN_XOR = 3'd5,
        FN_NOR = 3'd6,
        FN_ILL = 3'd7
    } func_t;

    localparam logic [2:0] SOP_AND  = 3'd0;
    localparam logic [2:0] SOP_OR   = 3'd1;
    localparam logic [2:0] SOP_ADD  = 3'd2;
    localparam logic [2:0] SOP_LESS = 3'd3;
    localparam logic [2:0] SOP_XOR  = 3'd4;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIX  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    typedef struct packed {
        logic       ainvert;
        logic       binvert;
        logic [2:0] op;
    } slice_ctrl_t;

    function automatic logic is_arith(input func_t fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT);
    endfunction

    // Slice controls for a given func in a given state; zero outside RUN/FIX.
    function automatic slice_ctrl_t decode_ctrl(input func_t fn, input state_t st);
        slice_ctrl_t c;
        c = '0;
        if (st == ST_RUN) begin
            case (fn)
                FN_AND: c.op = SOP_AND;
                FN_OR:  c.op = SOP_OR;
                FN_ADD: c.op = SOP_ADD;
                FN_SUB: begin c.op = SOP_ADD; c.binvert = 1'b1; end
                FN_SLT: begin c.op = SOP_ADD; c.binvert = 1'b1; end
                FN_XOR: c.op = SOP_XOR;
                FN_NOR: begin c.op = SOP_AND; c.ainvert = 1'b1; c.binvert = 1'b1; end
                default: c = '0;
            endcase
        end else if (st == ST_FIX) begin
            c.op = SOP_LESS;
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bus between the decode stage and the serial ALU sequencer.
interface alu_serial_ctrl_if
    import alu_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             start_valid;
    logic             start_ready;
    func_t            func;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             err;

    modport master (
        output start_valid, func, op_a, op_b, done_ready,
        input  start_ready, done_valid, result, zero, carry, overflow, err
    );

    modport slave (
        input  start_valid, func, op_a, op_b, done_ready,
        output start_ready, done_valid, result, zero, carry, overflow, err
    );
endinterface

// File: rtl/alu_serial_ctrl_operand_shreg.sv
// Parallel-load, shift-right operand register presenting its LSB serially.
module operand_shreg
    import alu_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             bit_out
);
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end else if (shift) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    assign bit_out = q[0];
endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving one external 1-bit ALU slice, LSB first.
module alu_serial_ctrl
    import alu_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_serial_ctrl_if.slave   bus,
    output logic               slice_a,
    output logic               slice_b,
    output logic               slice_ainvert,
    output logic               slice_binvert,
    output logic               slice_cin,
    output logic               slice_less,
    output logic [2:0]         slice_op,
    input  logic               slice_cout,
    input  logic               slice_result
);
    localparam int unsigned     IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_q, state_d;
    func_t            func_q, func_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             cin_q, cin_d;
    logic             less_q, less_d;
    logic             start_ready_q, start_ready_d;
    logic             done_valid_q, done_valid_d;
    slice_ctrl_t      ctrl_q, ctrl_d;
    logic             load, shift, set;
    logic [WIDTH-1:0] load_a, load_b;

    // Illegal requests load zeros so the slice operand lines stay quiet.
    assign load_a = (bus.func == FN_ILL) ? '0 : bus.op_a;
    assign load_b = (bus.func == FN_ILL) ? '0 : bus.op_b;

    operand_shreg #(.WIDTH(WIDTH)) u_shreg_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .shift   (shift),
        .data    (load_a),
        .bit_out (slice_a)
    );

    operand_shreg #(.WIDTH(WIDTH)) u_shreg_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .shift   (shift),
        .data    (load_b),
        .bit_out (slice_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            func_q        <= FN_AND;
            idx_q         <= '0;
            result_q      <= '0;
            carry_q       <= 1'b0;
            ovf_q         <= 1'b0;
            zero_q        <= 1'b0;
            err_q         <= 1'b0;
            cin_q         <= 1'b0;
            less_q        <= 1'b0;
            start_ready_q <= 1'b1;
            done_valid_q  <= 1'b0;
            ctrl_q        <= '0;
        end else begin
            state_q       <= state_d;
            func_q        <= func_d;
            idx_q         <= idx_d;
            result_q      <= result_d;
            carry_q       <= carry_d;
            ovf_q         <= ovf_d;
            zero_q        <= zero_d;
            err_q         <= err_d;
            cin_q         <= cin_d;
            less_q        <= less_d;
            start_ready_q <= start_ready_d;
            done_valid_q  <= done_valid_d;
            ctrl_q        <= ctrl_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        idx_d    = idx_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        err_d    = err_q;
        cin_d    = cin_q;
        less_d   = less_q;
        load     = 1'b0;
        shift    = 1'b0;
        set      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    load     = 1'b1;
                    func_d   = bus.func;
                    idx_d    = '0;
                    result_d = '0;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
                    less_d   = 1'b0;
                    err_d    = (bus.func == FN_ILL);
                    cin_d    = (bus.func == FN_SUB) || (bus.func == FN_SLT);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // An illegal func spends a single idle RUN cycle before reporting.
                if (err_q) begin
                    cin_d   = 1'b0;
                    zero_d  = (result_q == '0);
                    state_d = ST_DONE;
                end else begin
                    shift            = 1'b1;
                    result_d[idx_q]  = slice_result;
                    cin_d            = slice_cout;
                    idx_d            = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        carry_d = slice_cout;
                        ovf_d   = is_arith(func_q) & (cin_q ^ slice_cout);
                        set     = slice_result ^ ovf_d;
                        cin_d   = 1'b0;
                        zero_d  = (result_d == '0);
                        if (func_q == FN_SLT) begin
                            less_d  = set;
                            state_d = ST_FIX;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_FIX: begin
                result_d = WIDTH'(slice_result);
                zero_d   = ~slice_result;
                less_d   = 1'b0;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (bus.done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        start_ready_d = (state_d == ST_IDLE);
        done_valid_d  = (state_d == ST_DONE);
        ctrl_d        = decode_ctrl(func_d, state_d);
    end

    assign slice_ainvert = ctrl_q.ainvert;
    assign slice_binvert = ctrl_q.binvert;
    assign slice_op      = ctrl_q.op;
    assign slice_cin     = cin_q;
    assign slice_less    = less_q;

    assign bus.start_ready = start_ready_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.result      = result_q;
    assign bus.zero        = zero_q;
    assign bus.carry       = carry_q;
    assign bus.overflow    = ovf_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl with a behavioural 1-bit ALU slice.
module tb_alu_serial_ctrl;
    import alu_serial_pkg::*;

    localparam int unsigned W = 24;

    logic clk;
    logic rst_n;
    logic slice_a, slice_b, slice_ainvert, slice_binvert, slice_cin, slice_less;
    logic [2:0] slice_op;
    logic slice_cout, slice_result;

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .slice_a       (slice_a),
        .slice_b       (slice_b),
        .slice_ainvert (slice_ainvert),
        .slice_binvert (slice_binvert),
        .slice_cin     (slice_cin),
        .slice_less    (slice_less),
        .slice_op      (slice_op),
        .slice_cout    (slice_cout),
        .slice_result  (slice_result)
    );

    // Behavioural model of the external slice.
    always_comb begin
        logic a2, b2;
        a2 = slice_a ^ slice_ainvert;
        b2 = slice_b ^ slice_binvert;
        slice_cout = (a2 & b2) | (a2 & slice_cin) | (b2 & slice_cin);
        case (slice_op)
            3'd0:    slice_result = a2 & b2;
            3'd1:    slice_result = a2 | b2;
            3'd2:    slice_result = a2 ^ b2 ^ slice_cin;
            3'd3:    slice_result = slice_less;
            3'd4:    slice_result = a2 ^ b2;
            default: slice_result = 1'b0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] result;
        logic         zero;
        logic         carry;
        logic         ovf;
        logic         err;
        logic         chk_carry;
        int           lat;
        int           hold;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int issued = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input func_t f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic z, input logic c, input logic v,
                         input logic e, input logic cc, input int lat, input int hold,
                         input bit track);
        exp_t x;
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.start_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.start_ready) begin
            chk("start_ready_wait", 32'(bus.start_ready), 32'd1);
            return;
        end
        bus.start_valid = 1'b1;
        bus.func        = f;
        bus.op_a        = a;
        bus.op_b        = b;
        @(posedge clk);
        #1;
        x.result = r; x.zero = z; x.carry = c; x.ovf = v; x.err = e;
        x.chk_carry = cc; x.lat = lat; x.hold = hold; x.acc = cyc;
        if (track) begin
            sb.push_back(x);
            issued++;
        end
        bus.start_valid = 1'b0;
        bus.func        = FN_ILL;
        bus.op_a        = ~a;
        bus.op_b        = ~b;
        chk("start_ready_busy", 32'(bus.start_ready), 32'd0);
    endtask

    // Monitor: pop and compare whenever a result is presented, then accept it.
    initial begin
        exp_t e;
        logic [W+6:0] snap;
        bus.done_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done_valid) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done_valid), 32'd0);
                    e.hold = 0;
                end else begin
                    e = sb.pop_front();
                    chk("result", 32'(bus.result), 32'(e.result));
                    chk("zero", 32'(bus.zero), 32'(e.zero));
                    chk("overflow", 32'(bus.overflow), 32'(e.ovf));
                    chk("err", 32'(bus.err), 32'(e.err));
                    if (e.chk_carry) chk("carry", 32'(bus.carry), 32'(e.carry));
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
                snap = {bus.done_valid, bus.result, bus.zero, bus.carry, bus.overflow,
                        bus.err, bus.start_ready};
                for (int h = 0; h < e.hold; h++) begin
                    @(negedge clk);
                    chk("hold_stable", 32'({bus.done_valid, bus.result, bus.zero, bus.carry,
                        bus.overflow, bus.err, bus.start_ready}), 32'(snap));
                end
                bus.done_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.done_ready = 1'b0;
                chk("done_drop", 32'(bus.done_valid), 32'd0);
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bus.start_valid = 1'b0;
        bus.func = FN_AND;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
        chk("rst_done_valid", 32'(bus.done_valid), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_flags", 32'({bus.zero, bus.carry, bus.overflow, bus.err}), 32'd0);
        chk("rst_slice", 32'({slice_a, slice_b, slice_ainvert, slice_binvert, slice_cin,
            slice_less, slice_op}), 32'd0);
        rst_n = 1'b1;

        //     func    a          b          result     z     c     v     e     cc    lat hold
        issue(FN_ADD, 24'h7FFFFF, 24'h000001, 24'h800000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24, 0, 1'b1);
        issue(FN_SUB, 24'h000005, 24'h000005, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24, 0, 1'b1);
        issue(FN_SLT, 24'hFFFFFF, 24'h000001, 24'h000001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 25, 0, 1'b1);
        issue(FN_SLT, 24'h000001, 24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 25, 0, 1'b1);
        issue(FN_NOR, 24'h000000, 24'h000000, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24, 0, 1'b1);
        issue(FN_XOR, 24'hA5A5A5, 24'h0F0F0F, 24'hAAAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24, 10, 1'b1);
        issue(FN_AND, 24'hF0F0F0, 24'h3C3C3C, 24'h303030, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24, 0, 1'b1);
        issue(FN_OR,  24'hF0F0F0, 24'h3C3C3C, 24'hFCFCFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24, 0, 1'b1);
        issue(FN_SUB, 24'h000003, 24'h000005, 24'hFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24, 0, 1'b1);
        issue(FN_ADD, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24, 0, 1'b1);
        issue(FN_ILL, 24'h123456, 24'h654321, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 1'b1);

        // Abort an ADD at bit 12 with reset; the aborted result must never appear.
        issue(FN_ADD, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24, 0, 1'b0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("cin_mid_run", 32'(slice_cin), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_done_valid", 32'(bus.done_valid), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_flags", 32'({bus.zero, bus.carry, bus.overflow, bus.err}), 32'd0);
        chk("abort_start_ready", 32'(bus.start_ready), 32'd1);
        chk("abort_slice", 32'({slice_a, slice_b, slice_ainvert, slice_binvert, slice_cin,
            slice_less, slice_op}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(FN_ADD, 24'h000003, 24'h000004, 24'h000007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24, 0, 1'b1);

        n = 0;
        while ((sb.size() != 0 || bus.done_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("ops_completed", 32'(done_cnt), 32'(issued));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
